serial_adder: RTL



---
 rtl/serial_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add of a + b + cin, CHUNK bits per clock, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port computing a + ~b + 1.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_in;
    logic             w_cin_in;
    logic [CHUNK:0]   w_slice;
    logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract folds into the add: invert B and force the initial carry.
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    // New operands are taken only when no add is in flight.
    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST);

    // The single CHUNK-bit slice adder.
    assign w_slice = {1'b0, r_a[CHUNK-1:0]}
                   + {1'b0, r_b[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};

    // Result chunks enter at the MSB end so the LSB chunk ends at bit 0.
    assign w_acc_next = WIDTH'({w_slice[CHUNK-1:0], r_acc} >> CHUNK);

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand shifting, carry chaining and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_acc   <= '0;
            r_carry <= w_cin_in;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_acc   <= w_acc_next;
            r_carry <= w_slice[CHUNK];
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_slice[CHUNK];
            end
        end
    end

endmodule
